// File: rtl/pe_tap_sequencer.sv
// Tap sequencer for one MAC processing element: pairs streamed pixels with banked coefficients.
// Optional TAP_STALL_CNT_EN adds a saturating stall_cycles counter of RUN cycles without s_valid.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; coefficient bank writable
//   ST_RUN   | accepting pixels, issuing taps to the PE

module pe_tap_sequencer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int TAPS        = 9,
    parameter int CNT_WIDTH   = 4,
    parameter int WIN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   coeff_wr_en,
    input  logic [CNT_WIDTH-1:0]   coeff_wr_addr,
    input  logic [COEFF_WIDTH-1:0] coeff_wr_data,
    input  logic                   start,
    input  logic [WIN_WIDTH-1:0]   num_windows,
    input  logic                   abort,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    output logic                   pe_enable,
    output logic                   pe_clear,
    output logic [PIXEL_WIDTH-1:0] pe_pixel,
    output logic [COEFF_WIDTH-1:0] pe_coeff,
    output logic                   result_valid,
    output logic                   busy,
`ifdef TAP_STALL_CNT_EN
    output logic [15:0]            stall_cycles,
`endif
    output logic                   done
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [CNT_WIDTH:0]   TAPS_EXT = (CNT_WIDTH+1)'(TAPS);
    localparam logic [CNT_WIDTH-1:0] TAP_LAST = CNT_WIDTH'(TAPS - 1);

    state_t                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     tap_q, tap_d;
    logic [WIN_WIDTH-1:0]     win_left_q, win_left_d;
    logic [COEFF_WIDTH-1:0]   coeff_q [TAPS];
    logic                     coeff_we;

    logic                     pe_enable_q, pe_enable_d;
    logic                     pe_clear_q, pe_clear_d;
    logic [PIXEL_WIDTH-1:0]   pe_pixel_q, pe_pixel_d;
    logic [COEFF_WIDTH-1:0]   pe_coeff_q, pe_coeff_d;
    // win_end/run_end mark the cycle the PE receives a window's last tap
    logic                     win_end_q, win_end_d;
    logic                     run_end_q, run_end_d;
    logic                     result_valid_q;
    logic                     done_q, done_d;

    assign coeff_we = (state_q == ST_IDLE) && coeff_wr_en && ({1'b0, coeff_wr_addr} < TAPS_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coeff_q[i] <= '0;
            end
        end else if (coeff_we) begin
            coeff_q[coeff_wr_addr] <= coeff_wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        win_left_d  = win_left_q;
        pe_enable_d = 1'b0;
        pe_clear_d  = 1'b0;
        pe_pixel_d  = pe_pixel_q;
        pe_coeff_d  = pe_coeff_q;
        win_end_d   = 1'b0;
        run_end_d   = 1'b0;
        done_d      = run_end_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_windows != '0) begin
                        state_d    = ST_RUN;
                        win_left_d = num_windows;
                        tap_d      = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    tap_d      = '0;
                    win_left_d = '0;
                end else if (s_valid) begin
                    pe_enable_d = 1'b1;
                    pe_clear_d  = (tap_q == '0);
                    pe_pixel_d  = s_pixel;
                    pe_coeff_d  = coeff_q[tap_q];
                    if (tap_q == TAP_LAST) begin
                        tap_d      = '0;
                        win_left_d = win_left_q - 1'b1;
                        win_end_d  = 1'b1;
                        if (win_left_q == WIN_WIDTH'(1)) begin
                            run_end_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            tap_q          <= '0;
            win_left_q     <= '0;
            pe_enable_q    <= 1'b0;
            pe_clear_q     <= 1'b0;
            pe_pixel_q     <= '0;
            pe_coeff_q     <= '0;
            win_end_q      <= 1'b0;
            run_end_q      <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tap_q          <= tap_d;
            win_left_q     <= win_left_d;
            pe_enable_q    <= pe_enable_d;
            pe_clear_q     <= pe_clear_d;
            pe_pixel_q     <= pe_pixel_d;
            pe_coeff_q     <= pe_coeff_d;
            win_end_q      <= win_end_d;
            run_end_q      <= run_end_d;
            result_valid_q <= win_end_q;
            done_q         <= done_d;
        end
    end

`ifdef TAP_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            stall_q <= '0;
        end else if ((state_q == ST_RUN) && !s_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign s_ready      = (state_q == ST_RUN) && !abort;
    assign busy         = (state_q == ST_RUN);
    assign pe_enable    = pe_enable_q;
    assign pe_clear     = pe_clear_q;
    assign pe_pixel     = pe_pixel_q;
    assign pe_coeff     = pe_coeff_q;
    assign result_valid = result_valid_q;
    assign done         = done_q;

endmodule

// File: doc/pe_tap_sequencer.md
# pe_tap_sequencer

Drives one multiply-accumulate processing element (PE) through a convolution window. It accepts a pixel stream over a valid/ready handshake and pairs each pixel with the matching coefficient from an internal TAPS-entry coefficient bank. It then issues registered enable/clear/pixel/coeff to the PE and flags the cycle in which the PE accumulator holds a completed window sum. It sits between the line-buffer/window generator and the PE chain.

## Interface
- PIXEL_WIDTH, 8, pixel width; must match PE.
- COEFF_WIDTH, 8, coefficient width; must match PE.
- TAPS, 9, taps per window; 2 ≤ TAPS ≤ 2^CNT_WIDTH.
- CNT_WIDTH, 4, width of tap counter and coefficient address.
- WIN_WIDTH, 16, width of window count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- coeff_wr_en  in  1  coefficient write strobe, honoured only in IDLE.
- coeff_wr_addr  in  CNT_WIDTH  coefficient index; writes with address ≥ TAPS are ignored.
- coeff_wr_data  in  COEFF_WIDTH  coefficient value.
- start  in  1  one-cycle pulse; begins a run, honoured only in IDLE.
- num_windows  in  WIN_WIDTH  windows in the run; latched on start.
- abort  in  1  terminates the run immediately.
- s_valid  in  1  pixel valid.
- s_ready  out  1  pixel ready.
- s_pixel  in  PIXEL_WIDTH  pixel data.
- pe_enable  out  1  PE enable, registered.
- pe_clear  out  1  PE clear (first tap of window), registered.
- pe_pixel  out  PIXEL_WIDTH  PE pixel, registered.
- pe_coeff  out  COEFF_WIDTH  PE coefficient, registered.
- result_valid  out  1  one-cycle pulse; PE acc_out holds a complete window sum.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at run completion (not on abort).

## Operation
- Coefficient bank: TAPS registers, reset to 0.
  - Written in IDLE when coeff_wr_en=1 and addr<TAPS.
  - Writes in RUN are dropped.
- FSM states: IDLE, RUN.
  - IDLE→RUN on start with num_windows≠0. This latches win_left=num_windows and sets tap=0.
  - IDLE on start with num_windows=0: stay in IDLE and pulse done the next cycle.
  - RUN→IDLE when the last tap of the last window is accepted; done pulses the same cycle as that window's result_valid.
  - RUN→IDLE on abort, with priority over a handshake in the same cycle: that pixel is not accepted, tap and win_left are cleared, and no result_valid or done is raised for the partial window.
- s_ready = (state==RUN) && !abort, combinational.
- Each accepted pixel (s_valid && s_ready) registers:
  - pe_enable=1
  - pe_clear=(tap==0)
  - pe_pixel=s_pixel
  - pe_coeff=coeff[tap]
  - tap increments and wraps TAPS-1→0; win_left decrements on the wrap.
- No handshake: pe_enable=0, pe_clear=0, and pe_pixel/pe_coeff hold their values, so the PE holds its accumulator. Bubbles of any length are legal mid-window.
- start while in RUN is ignored. A coefficient write and start in the same IDLE cycle: the write takes effect before the first tap.

## Timing
- Reset values: all outputs 0; state IDLE; tap 0; win_left 0; coefficients 0.
- Handshake at edge N → pe_* valid after edge N → PE captures at edge N+1.
- result_valid asserts after edge N+1 for the last tap of a window, so it is aligned with the PE acc_out holding the sum. Latency is 2 cycles from the last-tap handshake.
- Full throughput: one pixel per cycle, back-to-back windows with no gap. pe_clear on tap 0 of window k+1 overlaps with nothing because the PE overwrites its accumulator.
- busy drops on the edge after the final handshake. done and the final result_valid follow one cycle later.

## Configuration
- TAP_STALL_CNT_EN defined: adds output stall_cycles (16 bits).
  - Counts RUN cycles with s_valid=0.
  - Saturates at 0xFFFF, clears on an accepted start, resets to 0.
- TAP_STALL_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Load coefficients 1..9, start with num_windows=1, stream pixels 1..9 back-to-back:
  - pe_clear only with pixel 1.
  - result_valid 2 cycles after the 9th handshake, with PE acc_out=285.
  - done in the same cycle.
- num_windows=3, continuous pixels=2, all coefficients=3:
  - three result_valid pulses 9 cycles apart, each with acc=54.
  - done with the third pulse.
- Same as the first scenario with s_valid low for 4 cycles after tap 4:
  - pe_enable=0 during the gap.
  - final acc=285, and result_valid is delayed by 4 cycles.
- abort asserted on tap 5 of window 2 (s_valid=1):
  - s_ready=0, pixel not accepted, no result_valid, no done.
  - busy=0 on the next cycle.
  - A new start+window yields the correct sum.
- Coefficient write with addr=3, data=0x55 during RUN, and with addr=12 in IDLE: bank unchanged, verified through pe_coeff on the next run.
- start with num_windows=0: busy stays 0, done pulses after 1 cycle, pe_enable stays 0. Mid-run rst_n low: all outputs 0 asynchronously.
